dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port 12-bit data memory between `NCORES` processor cores and the host loader in the multi-core matrix-multiply build. Host loading uses the memory's receive port. Core loads and stores are granted round-robin, one per cycle, and drive the memory's main address/write port. Read data returns with fixed latency on a shared response bus, tagged per core.

## Interface
- `NCORES`, 4: number of requesting cores (2..8).
- `N`, 17: bus word width; memory stores the low 12 bits.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NCORES: per-core access request; held until accepted.
- `req_we` in NCORES: 1 = store, 0 = load.
- `req_addr` in NCORES*12: core i address in bits [12i+11:12i].
- `req_wdata` in NCORES*N: core i store data in bits [Ni+N-1:Ni].
- `req_ready` out NCORES: one-hot grant, combinational; accept = valid & ready.
- `rsp_valid` out NCORES: one-hot; load data for core i is on `rsp_data` this cycle.
- `rsp_data` out 12: shared load data (= `mem_dataout`).
- `host_valid` in 1: host load beat present.
- `host_addr` in 12, `host_data` in N: host beat address and data.
- `host_ready` out 1: high in LOAD state only.
- `start` in 1: end loading and enter RUN.
- `load_req` in 1: return to LOAD after draining.
- `busy` out 1: a load is in flight.
- `mem_write_en` out 1, `mem_addr` out 12, `mem_datain` out N: memory main port.
- `mem_dataout` in 12: memory registered read data.
- `mem_receive_en` out 1, `mem_addr_input` out 12, `mem_data_input` out N: memory receive port.

## Operation
- States: LOAD (after reset), RUN, DRAIN.
- LOAD:
  - `host_ready`=1 and all `req_ready`=0.
  - An accepted host beat is registered onto `mem_receive_en`/`mem_addr_input`/`mem_data_input` for exactly one cycle.
  - `start`=1 moves to RUN at the next edge. A host beat presented in the same cycle is still accepted.
- RUN:
  - `host_ready`=0.
  - Grant goes to the first core with `req_valid`=1, searching upward from `last+1` modulo NCORES, where `last` is the most recently granted core.
  - At most one grant per cycle; `last` updates only on a grant.
  - An accepted request is registered onto the memory main port for one cycle: `mem_write_en`=`req_we`, `mem_addr`, `mem_datain`.
  - For a load, the core index is carried through a 2-stage tag pipeline that drives `rsp_valid`.
- `load_req`=1 in RUN moves to DRAIN, ignoring `start`. No grants are made in DRAIN.
- DRAIN moves to LOAD once the tag pipeline is empty (`busy`=0). It takes 0 extra cycles if already empty.
- When no access is granted, `mem_write_en`=0 and `mem_addr` holds its last value. The memory keeps re-reading that address, which is harmless because `rsp_valid` qualifies `rsp_data`.
- Store data is passed through as the full N bits; truncation to 12 bits happens in memory.
- A host beat and a core store never share a cycle, so there is no same-address write race.
- Reset values:
  - State LOAD, `last`=NCORES-1, so core 0 wins first.
  - `mem_write_en`=0, `mem_receive_en`=0, `mem_addr`=0, `mem_addr_input`=0, `mem_datain`=0, `mem_data_input`=0.
  - Tag pipeline cleared: `rsp_valid`=0, `busy`=0.
- Reset during an in-flight load discards the response; no `rsp_valid` is produced after reset.

## Timing
- Request accepted at edge k; memory port driven during cycle k+1; memory captures `dataout` at edge k+1.
- `rsp_valid[i]` is high for one cycle, from edge k+1 to edge k+2. Load latency is 2 edges.
- Stores complete at edge k+1 and produce no response.
- A load to an address stored one grant earlier returns the new value.
- Throughput is one core access per cycle. With all cores requesting, each core is granted once every NCORES cycles.
- Host beat accepted at edge k is written to memory at edge k+1. Throughput is 1 beat per cycle.
- `busy` is high while either tag stage holds a load.

## Test plan
- Load, then read: reset, then host beats (addr 4 ← 1, 5 ← 2, 68 ← 3), then `start`. Core 0 loads addr 68 → `rsp_valid`=0001 and `rsp_data`=3 exactly 2 edges after accept.
- Round-robin fairness: all 4 cores hold loads after `start` → grant order 0,1,2,3,0,…. Each grant is one cycle, and `rsp_valid` follows the same order with 2-cycle lag.
- Back-to-back store then load: core 2 stores 0x1ABC (17-bit) to addr 7, then loads addr 7 next cycle → `rsp_data`=0xABC.
- Drain: `load_req` asserted the same cycle core 1's load is accepted → core 1 still gets `rsp_valid`. There are no further grants, `host_ready` rises only after `busy` falls, and `start` during DRAIN is ignored.
- Simultaneity: `start` with `host_valid` (addr 9 ← 5) → beat written, then RUN. Core 3 requesting in the same cycle is not granted that cycle.
- Reset mid-flight: `rst` at edge k+1 after a load accepted at edge k → `rsp_valid` stays 0. The state is LOAD, and the next RUN grant goes to core 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the host loader fills memory in LOAD, then cores share the
// main port round-robin in RUN; load responses return through a 2-stage tag pipeline.
module dmem_arbiter #(
  parameter int NCORES = 4,
  parameter int N      = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCORES-1:0]     req_valid,
  input  logic [NCORES-1:0]     req_we,
  input  logic [NCORES*12-1:0]  req_addr,
  input  logic [NCORES*N-1:0]   req_wdata,
  output logic [NCORES-1:0]     req_ready,
  output logic [NCORES-1:0]     rsp_valid,
  output logic [11:0]           rsp_data,
  input  logic                  host_valid,
  input  logic [11:0]           host_addr,
  input  logic [N-1:0]          host_data,
  output logic                  host_ready,
  input  logic                  start,
  input  logic                  load_req,
  output logic                  busy,
  output logic                  mem_write_en,
  output logic [11:0]           mem_addr,
  output logic [N-1:0]          mem_datain,
  input  logic [11:0]           mem_dataout,
  output logic                  mem_receive_en,
  output logic [11:0]           mem_addr_input,
  output logic [N-1:0]          mem_data_input
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NCORES - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          grant_en;
  logic          host_rdy;
  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic          accept;
  logic          host_acc;
  logic          sel_we;
  logic [11:0]   sel_addr;
  logic [N-1:0]  sel_wdata;
  logic [IW-1:0] last_q;

  logic          vld_p0_q, vld_p1_q;
  logic [IW-1:0] tag_p0_q, tag_p1_q;

  logic          mem_write_en_q;
  logic [11:0]   mem_addr_q;
  logic [N-1:0]  mem_datain_q;
  logic          mem_receive_en_q;
  logic [11:0]   mem_addr_input_q;
  logic [N-1:0]  mem_data_input_q;

  // Core index reached by stepping 'off' places above 'base', wrapping at NCORES.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCORES) s = s - NCORES;
    return s[IW-1:0];
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // FSM: next state (load_req wins over start while running)
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (start)    state_d = S_RUN;
      S_RUN:   if (load_req) state_d = S_DRAIN;
      S_DRAIN: if (!busy)    state_d = S_LOAD;
      default:               state_d = S_LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    host_rdy = (state_q == S_LOAD);
    grant_en = (state_q == S_RUN);
  end

  // Round-robin search starting just above the last granted core
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int off = 1; off <= NCORES; off++) begin
      if (!gnt_found && req_valid[rr_index(last_q, off)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_index(last_q, off);
      end
    end
  end

  assign accept   = grant_en & gnt_found;
  assign host_acc = host_rdy & host_valid;

  always_comb begin
    req_ready = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (int'(gnt_idx) == i) begin
        req_ready[i] = accept;
        sel_we       = req_we[i];
        sel_addr     = req_addr[i*12 +: 12];
        sel_wdata    = req_wdata[i*N +: N];
      end
    end
  end

  // Stage p0 -> p1: load tag follows the memory's registered read
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= LAST_RST;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      tag_p0_q <= '0;
      tag_p1_q <= '0;
    end else begin
      if (accept) last_q <= gnt_idx;
      vld_p0_q <= accept & ~sel_we;
      tag_p0_q <= gnt_idx;
      vld_p1_q <= vld_p0_q;
      tag_p1_q <= tag_p0_q;
    end
  end

  // Memory ports; the main address holds between grants
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_write_en_q   <= 1'b0;
      mem_addr_q       <= '0;
      mem_datain_q     <= '0;
      mem_receive_en_q <= 1'b0;
      mem_addr_input_q <= '0;
      mem_data_input_q <= '0;
    end else begin
      mem_write_en_q   <= accept & sel_we;
      if (accept) begin
        mem_addr_q   <= sel_addr;
        mem_datain_q <= sel_wdata;
      end
      mem_receive_en_q <= host_acc;
      if (host_acc) begin
        mem_addr_input_q <= host_addr;
        mem_data_input_q <= host_data;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NCORES; i++) begin
      rsp_valid[i] = vld_p1_q && (int'(tag_p1_q) == i);
    end
  end

  assign rsp_data       = mem_dataout;
  assign busy           = vld_p0_q | vld_p1_q;
  assign host_ready     = host_rdy;
  assign mem_write_en   = mem_write_en_q;
  assign mem_addr       = mem_addr_q;
  assign mem_datain     = mem_datain_q;
  assign mem_receive_en = mem_receive_en_q;
  assign mem_addr_input = mem_addr_input_q;
  assign mem_data_input = mem_data_input_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: random core/host traffic against a memory model, with a
// transaction-level reference (array memory + round-robin rule) feeding a response scoreboard.
module tb_dmem_arbiter;
  localparam int NC = 4;
  localparam int NW = 17;
  localparam int M_LOAD = 0, M_RUN = 1, M_DRAIN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NC-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NC*12-1:0]  req_addr;
  logic [NC*NW-1:0]  req_wdata;
  logic [11:0]       rsp_data;
  logic              host_valid, host_ready, start, load_req, busy;
  logic [11:0]       host_addr;
  logic [NW-1:0]     host_data;
  logic              mem_write_en, mem_receive_en;
  logic [11:0]       mem_addr, mem_addr_input;
  logic [NW-1:0]     mem_datain, mem_data_input;
  logic [11:0]       mem_dataout;

  dmem_arbiter #(.NCORES(NC), .N(NW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready), .start(start), .load_req(load_req), .busy(busy),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .mem_receive_en(mem_receive_en),
    .mem_addr_input(mem_addr_input), .mem_data_input(mem_data_input)
  );

  // Single-port 12-bit memory with registered read and a separate receive write port
  logic [11:0] mem [4096];
  bit mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      mem_dataout <= '0;
      mem_clr     <= 1'b0;
    end else begin
      mem_dataout <= mem[mem_addr];
      if (mem_write_en)   mem[mem_addr]       <= mem_datain[11:0];
      if (mem_receive_en) mem[mem_addr_input] <= mem_data_input[11:0];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int          core;
    logic [11:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [11:0]   ref_mem [4096];
  int            m_state, m_last;
  bit            m_fl0, m_fl1;
  bit            m_we, m_rcv_en;
  logic [11:0]   m_addr, m_rcv_addr;
  logic [NW-1:0] m_wdata, m_rcv_data;

  // Pending per-core requests, held until granted
  bit            pv [NC];
  bit            pwe [NC];
  logic [11:0]   paddr [NC];
  logic [NW-1:0] pdat [NC];

  exp_t mon_e;
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_core", 32'(rsp_valid), 32'(1 << mon_e.core));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  function automatic bit any_pv();
    bit a = 1'b0;
    for (int i = 0; i < NC; i++) a |= pv[i];
    return a;
  endfunction

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      req_valid[i]             = pv[i];
      req_we[i]                = pwe[i];
      req_addr[i*12 +: 12]     = paddr[i];
      req_wdata[i*NW +: NW]    = pdat[i];
    end
  endtask

  task automatic model_reset();
    m_state = M_LOAD; m_last = NC - 1; m_fl0 = 0; m_fl1 = 0;
    m_we = 0; m_addr = '0; m_wdata = '0;
    m_rcv_en = 0; m_rcv_addr = '0; m_rcv_data = '0;
  endtask

  task automatic idle_inputs();
    start = 0; load_req = 0; host_valid = 0; host_addr = '0; host_data = '0;
    for (int i = 0; i < NC; i++) begin pv[i] = 0; pwe[i] = 0; paddr[i] = '0; pdat[i] = '0; end
  endtask

  // One clock: check combinational and registered outputs, then advance the model
  task automatic step();
    int g, c;
    bit busy_now, hacc, newfl;
    exp_t e;
    drive();
    @(negedge clk); #1;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("rsp_missing", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    g = -1;
    if (m_state == M_RUN) begin
      for (int k = 1; k <= NC; k++) begin
        c = (m_last + k) % NC;
        if (g < 0 && pv[c]) g = c;
      end
    end
    busy_now = m_fl0 | m_fl1;
    chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
    chk("host_ready", 32'(host_ready), 32'(m_state == M_LOAD));
    chk("busy", 32'(busy), 32'(busy_now));
    chk("mem_write_en", 32'(mem_write_en), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (m_we) chk("mem_datain", 32'(mem_datain), 32'(m_wdata));
    chk("mem_receive_en", 32'(mem_receive_en), 32'(m_rcv_en));
    if (m_rcv_en) begin
      chk("mem_addr_input", 32'(mem_addr_input), 32'(m_rcv_addr));
      chk("mem_data_input", 32'(mem_data_input), 32'(m_rcv_data));
    end
    hacc = (m_state == M_LOAD) && host_valid;
    m_rcv_en = hacc;
    if (hacc) begin
      m_rcv_addr = host_addr; m_rcv_data = host_data;
      ref_mem[host_addr] = host_data[11:0];
    end
    m_we = 0;
    newfl = 0;
    if (g >= 0) begin
      m_last = g; m_we = pwe[g]; m_addr = paddr[g]; m_wdata = pdat[g];
      if (pwe[g]) ref_mem[paddr[g]] = pdat[g][11:0];
      else begin
        e.core = g; e.data = ref_mem[paddr[g]]; e.cyc = cyc + 2;
        sb.push_back(e);
        newfl = 1;
      end
      pv[g] = 0;
    end
    m_fl1 = m_fl0; m_fl0 = newfl;
    case (m_state)
      M_LOAD:  if (start)     m_state = M_RUN;
      M_RUN:   if (load_req)  m_state = M_DRAIN;
      default: if (!busy_now) m_state = M_LOAD;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    drive();
    @(negedge clk); #1;
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic host_beat(input logic [11:0] a, input logic [NW-1:0] d);
    host_valid = 1; host_addr = a; host_data = d;
    step();
    host_valid = 0;
  endtask

  task automatic refill(input int pct, input bit allow_store, input int amax);
    for (int i = 0; i < NC; i++) begin
      if (!pv[i] && ($urandom_range(99) < pct)) begin
        pv[i]    = 1;
        pwe[i]   = allow_store ? 1'($urandom_range(1)) : 1'b0;
        paddr[i] = 12'($urandom_range(amax));
        pdat[i]  = NW'($urandom);
      end
    end
  endtask

  task automatic drain_pending();
    for (int t = 0; t < 64; t++) begin
      if (!any_pv()) break;
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    rst = 1;
    idle_inputs();
    drive();
    model_reset();
    do_reset();

    // Reset values
    @(negedge clk); #1;
    chk("rst_mem_write_en", 32'(mem_write_en), 32'd0);
    chk("rst_mem_receive_en", 32'(mem_receive_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_addr_input", 32'(mem_addr_input), 32'd0);
    chk("rst_mem_datain", 32'(mem_datain), 32'd0);
    chk("rst_mem_data_input", 32'(mem_data_input), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;

    // Host load, then start with a simultaneous beat and held core requests
    host_beat(12'd4, 17'd1);
    host_beat(12'd5, 17'd2);
    host_beat(12'd68, 17'd3);
    pv[0] = 1; pwe[0] = 0; paddr[0] = 12'd68;
    pv[3] = 1; pwe[3] = 0; paddr[3] = 12'd9;
    start = 1; host_valid = 1; host_addr = 12'd9; host_data = 17'd5;
    step();
    start = 0; host_valid = 0;
    repeat (5) step();

    // Round-robin with every core holding a load
    for (int t = 0; t < 12; t++) begin
      refill(100, 1'b0, 70);
      step();
    end
    drain_pending();
    repeat (3) step();

    // Store then load to the same address from core 2
    pv[2] = 1; pwe[2] = 1; paddr[2] = 12'd7; pdat[2] = 17'h1ABC;
    step();
    pv[2] = 1; pwe[2] = 0; paddr[2] = 12'd7;
    step();
    repeat (3) step();

    // Random mixed traffic while running
    for (int t = 0; t < 150; t++) begin
      refill(50, 1'b1, 15);
      step();
    end
    drain_pending();
    repeat (3) step();

    // Drain: load_req with core 1's load; start during DRAIN ignored
    pv[1] = 1; pwe[1] = 0; paddr[1] = 12'd5;
    load_req = 1;
    step();
    load_req = 0;
    pv[0] = 1; pwe[0] = 0; paddr[0] = 12'd4;
    pv[2] = 1; pwe[2] = 0; paddr[2] = 12'd68;
    start = 1;
    repeat (2) step();
    start = 0;
    repeat (3) step();
    host_beat(12'd4, 17'h0_0777);
    start = 1;
    step();
    start = 0;
    drain_pending();
    repeat (3) step();

    // Reset with a load in flight
    pv[2] = 1; pwe[2] = 0; paddr[2] = 12'd4;
    step();
    do_reset();
    repeat (3) step();
    for (int i = 0; i < NC; i++) begin pv[i] = 1; pwe[i] = 0; paddr[i] = 12'(i + 4); end
    start = 1;
    step();
    start = 0;
    drain_pending();
    repeat (3) step();

    // Fully random control and traffic
    for (int t = 0; t < 600; t++) begin
      refill(40, 1'b1, 15);
      start      = ($urandom_range(19) == 0);
      load_req   = ($urandom_range(19) == 0);
      host_valid = 1'($urandom_range(1));
      host_addr  = 12'($urandom_range(15));
      host_data  = NW'($urandom);
      if ($urandom_range(199) == 0) do_reset();
      else step();
    end

    idle_inputs();
    repeat (4) step();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
